// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops words from a FIFO and sends each as a start/data(LSB first)/stop serial frame.
module fifo_serial_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_enable,
   input  logic                  i_f_empty_n,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   output logic                  o_read,
   output logic                  o_tx,
   output logic                  o_busy,
   output logic                  o_tx_done
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int NW = $clog2(DATA_WIDTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
   localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_WIDTH - 1);
   localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;
   state_t                r_state;
   logic [BW-1:0]         r_baud;
   logic [NW-1:0]         r_bit;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic                  r_read, r_tx, r_busy, r_tx_done;
   logic                  w_bit_end;
   assign w_bit_end = r_baud == BAUD_LAST;
   assign o_read    = r_read;
   assign o_tx      = r_tx;
   assign o_busy    = r_busy;
   assign o_tx_done = r_tx_done;
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit     <= '0;
         r_shreg   <= '0;
         r_read    <= 1'b0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_tx_done <= 1'b0;
      end else begin
         r_read    <= 1'b0;
         r_tx_done <= 1'b0;
         case (r_state)
            S_IDLE: if (i_enable && i_f_empty_n) begin
               r_state <= S_LOAD;
               r_read  <= 1'b1;
               r_busy  <= 1'b1;
            end
            S_LOAD: begin
               r_shreg <= i_fifo_data;
               r_state <= S_START;
               r_tx    <= 1'b0;
               r_baud  <= '0;
            end
            S_START: if (w_bit_end) begin
               r_state <= S_DATA;
               r_baud  <= '0;
               r_bit   <= '0;
               r_tx    <= r_shreg[0];
            end else r_baud <= r_baud + 1'b1;
            // tx is registered, so the next bit is taken from shreg[1] before the shift lands
            S_DATA: if (w_bit_end) begin
               r_baud  <= '0;
               r_shreg <= r_shreg >> 1;
               if (r_bit == BIT_LAST) begin
                  r_state <= S_STOP;
                  r_bit   <= '0;
                  r_tx    <= 1'b1;
               end else begin
                  r_bit <= r_bit + 1'b1;
                  r_tx  <= r_shreg[1];
               end
            end else r_baud <= r_baud + 1'b1;
            S_STOP: begin
               if (r_bit == STOP_LAST && r_baud == BAUD_PRE) r_tx_done <= 1'b1;
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (r_bit == STOP_LAST) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_bit   <= '0;
                  end else r_bit <= r_bit + 1'b1;
               end else r_baud <= r_baud + 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
